// File: rtl/multicycle_control_fsm.sv
// Main control unit of the multicycle RV32I core: sequences fetch/decode/execute/
// memory/writeback and drives ALU operation, datapath selects and write strobes.
package alu_op_pkg;
  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_LT     = 4'd3,
    ALU_LTU    = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_EQUAL  = 4'd10,
    ALU_NEQUAL = 4'd11,
    ALU_GT     = 4'd12,
    ALU_GTU    = 4'd13,
    ALU_BPS2   = 4'd14
  } aluOpType;
endpackage

module multicycle_control_fsm
  import alu_op_pkg::*;
#(
  parameter int RESET_TRAP_CLEAR = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Opcode,
  input  logic [2:0] Funct3,
  input  logic       Funct7b5,
  input  logic       CmpResult,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [2:0] ImmSrc,
  output logic       JalrMask,
  output aluOpType   Operation,
  output logic       IllegalInstr
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECR    = 4'd6;
  localparam logic [3:0] EXECI    = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BRANCH   = 4'd9;
  localparam logic [3:0] JAL      = 4'd10;
  localparam logic [3:0] JALR1    = 4'd11;
  localparam logic [3:0] JALR2    = 4'd12;
  localparam logic [3:0] LUI      = 4'd13;
  localparam logic [3:0] AUIPC    = 4'd14;
  localparam logic [3:0] TRAP     = 4'd15;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // The sticky trap flag is cleared on every rst for any value of RESET_TRAP_CLEAR.
  localparam logic TRAP_CLEAR_ON_RST = 1'b1 | (RESET_TRAP_CLEAR != 0);

  logic [3:0] state_r;
  logic [3:0] next_state_s;
  logic       illegal_r;

  function automatic aluOpType arith_op(input logic [2:0] f3, input logic f7b5, input logic is_r);
    aluOpType op;
    case (f3)
      3'b000:  op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_LT;
      3'b011:  op = ALU_LTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic aluOpType branch_op(input logic [2:0] f3);
    aluOpType op;
    case (f3)
      3'b000:  op = ALU_EQUAL;
      3'b001:  op = ALU_NEQUAL;
      3'b100:  op = ALU_LT;
      3'b101:  op = ALU_GT;
      3'b110:  op = ALU_LTU;
      3'b111:  op = ALU_GTU;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // Next-state selection.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      FETCH:    next_state_s = MemReady ? DECODE : FETCH;
      DECODE: begin
        case (Opcode)
          OP_LOAD, OP_STORE: next_state_s = (Funct3 == 3'b010) ? MEMADR : TRAP;
          OP_RTYPE:          next_state_s = EXECR;
          OP_ITYPE:          next_state_s = EXECI;
          OP_BRANCH:         next_state_s = (Funct3[2:1] == 2'b01) ? TRAP : BRANCH;
          OP_JAL:            next_state_s = JAL;
          OP_JALR:           next_state_s = (Funct3 == 3'b000) ? JALR1 : TRAP;
          OP_LUI:            next_state_s = LUI;
          OP_AUIPC:          next_state_s = AUIPC;
          default:           next_state_s = TRAP;
        endcase
      end
      MEMADR:   next_state_s = (Opcode == OP_STORE) ? MEMWRITE : MEMREAD;
      MEMREAD:  next_state_s = MemReady ? MEMWB : MEMREAD;
      MEMWB:    next_state_s = FETCH;
      MEMWRITE: next_state_s = MemReady ? FETCH : MEMWRITE;
      EXECR:    next_state_s = ALUWB;
      EXECI:    next_state_s = ALUWB;
      ALUWB:    next_state_s = FETCH;
      BRANCH:   next_state_s = FETCH;
      JAL:      next_state_s = ALUWB;
      JALR1:    next_state_s = JALR2;
      JALR2:    next_state_s = ALUWB;
      LUI:      next_state_s = ALUWB;
      AUIPC:    next_state_s = ALUWB;
      TRAP:     next_state_s = TRAP;
      default:  next_state_s = FETCH;
    endcase
  end

  // State register and sticky illegal-instruction flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= FETCH;
      illegal_r <= ~TRAP_CLEAR_ON_RST;
    end else begin
      state_r <= next_state_s;
      if (next_state_s == TRAP) begin
        illegal_r <= 1'b1;
      end else begin
        illegal_r <= illegal_r;
      end
    end
  end

  assign IllegalInstr = illegal_r;

  // Immediate format follows the opcode in every state.
  always_comb begin
    case (Opcode)
      OP_STORE:         ImmSrc = 3'b001;
      OP_BRANCH:        ImmSrc = 3'b010;
      OP_LUI, OP_AUIPC: ImmSrc = 3'b011;
      OP_JAL:           ImmSrc = 3'b100;
      default:          ImmSrc = 3'b000;
    endcase
  end

  // Per-state strobes and selects; rst forces everything to idle combinationally
  // so an in-flight memory request drops without waiting for a clock.
  always_comb begin
    MemReq    = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    JalrMask  = 1'b0;
    Operation = ALU_ADD;
    if (!rst) begin
      case (state_r)
        FETCH: begin
          MemReq  = 1'b1;
          ALUSrcB = 2'b10;
          if (MemReady) begin
            IRWrite   = 1'b1;
            PCWrite   = 1'b1;
            ResultSrc = 2'b10;
          end else begin
            IRWrite = 1'b0;
          end
        end
        DECODE: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
        end
        MEMADR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
        end
        MEMREAD: begin
          MemReq = 1'b1;
          AdrSrc = 1'b1;
        end
        MEMWB: begin
          ResultSrc = 2'b01;
          RegWrite  = 1'b1;
        end
        MEMWRITE: begin
          MemReq   = 1'b1;
          MemWrite = 1'b1;
          AdrSrc   = 1'b1;
        end
        EXECR: begin
          ALUSrcA   = 2'b10;
          Operation = arith_op(Funct3, Funct7b5, 1'b1);
        end
        EXECI: begin
          ALUSrcA   = 2'b10;
          ALUSrcB   = 2'b01;
          Operation = arith_op(Funct3, Funct7b5, 1'b0);
        end
        ALUWB:    RegWrite = 1'b1;
        BRANCH: begin
          ALUSrcA   = 2'b10;
          PCWrite   = CmpResult;
          Operation = branch_op(Funct3);
        end
        JAL: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
          PCWrite = 1'b1;
        end
        JALR1: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
        end
        JALR2: begin
          ALUSrcA  = 2'b01;
          ALUSrcB  = 2'b10;
          PCWrite  = 1'b1;
          JalrMask = 1'b1;
        end
        LUI: begin
          ALUSrcB   = 2'b01;
          Operation = ALU_BPS2;
        end
        AUIPC: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
        end
        TRAP:     Operation = ALU_ADD;
        default:  Operation = ALU_ADD;
      endcase
    end else begin
      Operation = ALU_ADD;
    end
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control unit for the multicycle RV32I core; it sits opposite the ALU on the Operation interface.
- Decodes the latched instruction fields and sequences fetch/decode/execute/memory/writeback states.
- Each cycle it drives the ALU operation, datapath mux selects and write strobes.
- Implements the memory request/ready handshake and branch resolution from the ALU compare result.

Parameters:
RESET_TRAP_CLEAR, 1, 1 = reset clears the sticky IllegalInstr flag; 0 = only a full reset after power-up clears it (always cleared by rst in this revision; kept for a future debug restart)

Ports:
clk  input  1  core clock
rst  input  1  reset, asynchronous, active-high
Opcode  input  7  instruction register bits [6:0]
Funct3  input  3  instruction register bits [14:12]
Funct7b5  input  1  instruction register bit 30
CmpResult  input  1  ALUResult[0] fed back for branch decisions
MemReady  input  1  memory completes the current request this cycle
MemReq  output  1  memory request valid
MemWrite  output  1  request is a store (qualifies MemReq)
AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut
IRWrite  output  1  latch instruction and OldPC
PCWrite  output  1  load PC from Result
RegWrite  output  1  register file write enable
ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = RD1
ALUSrcB  output  2  00 = RD2, 01 = ImmExt, 10 = constant 4
ResultSrc  output  2  00 = ALUOut, 01 = memory data register, 10 = ALUResult
ImmSrc  output  3  000 = I, 001 = S, 010 = B, 011 = U, 100 = J
JalrMask  output  1  datapath clears Result[0] for the PC write
Operation  output  aluOpType  ALU operation
IllegalInstr  output  1  sticky illegal-instruction flag

Behaviour:
- Reset: async, active-high. State goes to FETCH; IllegalInstr = 0. While rst is high, MemReq, MemWrite, IRWrite, PCWrite, RegWrite and JalrMask are forced 0. Selects read 0 and Operation reads ALU_ADD.
- Defaults in every state: strobes 0, Operation = ALU_ADD, selects 0. ImmSrc is always decoded from Opcode.
- FETCH:
  - MemReq = 1, AdrSrc = 0; SrcA = PC, SrcB = 4, ALU_ADD.
  - Hold while MemReady = 0.
  - On MemReady = 1 in the same cycle: IRWrite = 1, PCWrite = 1, ResultSrc = 10; next state DECODE.
- DECODE: SrcA = OldPC, SrcB = Imm, ALU_ADD, so the branch/JAL target lands in ALUOut. Next state by Opcode:
  - 0000011 -> MEMADR (load)
  - 0100011 -> MEMADR (store)
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR1
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - Any other opcode -> TRAP.
  - Load/store with Funct3 != 010 -> TRAP.
  - JALR with Funct3 != 000 -> TRAP.
  - Illegal branch Funct3 (010, 011) -> TRAP.
- MEMADR: SrcA = RD1, SrcB = Imm, ALU_ADD. Next state MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: MemReq = 1, AdrSrc = 1; hold until MemReady; then MEMWB.
- MEMWB: ResultSrc = 01, RegWrite = 1; next state FETCH.
- MEMWRITE: MemReq = 1, MemWrite = 1, AdrSrc = 1; hold until MemReady; then FETCH.
- EXECR / EXECI: SrcA = RD1; SrcB = RD2 (EXECR) or Imm (EXECI). Next state ALUWB. Funct3 map:
  - 000: ALU_ADD, or ALU_SUB only for EXECR with Funct7b5 = 1
  - 001: ALU_SLL
  - 010: ALU_LT
  - 011: ALU_LTU
  - 100: ALU_XOR
  - 101: ALU_SRA if Funct7b5 = 1, else ALU_SRL (both R and I forms)
  - 110: ALU_OR
  - 111: ALU_AND
- ALUWB: ResultSrc = 00, RegWrite = 1; next state FETCH.
- BRANCH: SrcA = RD1, SrcB = RD2, ResultSrc = 00, PCWrite = CmpResult; next state FETCH. Funct3 map:
  - 000: ALU_EQUAL
  - 001: ALU_NEQUAL
  - 100: ALU_LT
  - 101: ALU_GT
  - 110: ALU_LTU
  - 111: ALU_GTU
- JAL: SrcA = OldPC, SrcB = 4, ALU_ADD, ResultSrc = 00, PCWrite = 1; next state ALUWB (writes OldPC + 4).
- JALR1: SrcA = RD1, SrcB = Imm, ALU_ADD; next state JALR2.
- JALR2: SrcA = OldPC, SrcB = 4, ALU_ADD, ResultSrc = 00, PCWrite = 1, JalrMask = 1; next state ALUWB.
- LUI: SrcB = Imm, Operation = ALU_BPS2; next state ALUWB.
- AUIPC: SrcA = OldPC, SrcB = Imm, ALU_ADD; next state ALUWB.
- TRAP: IllegalInstr is set on entry and the FSM stays in TRAP with all strobes 0 until rst.
- MemReady outside FETCH, MEMREAD and MEMWRITE is ignored.
- An async reset mid-request drops MemReq in the same cycle.
- Every strobe is a single-cycle pulse, except MemReq/MemWrite, which hold steady until MemReady.

Test Plan:
- FETCH handshake: MemReady held low for 3 cycles, then high -> MemReq high for all 4 cycles; IRWrite and PCWrite high in the 4th cycle only; DECODE follows.
- R-type sub: Opcode = 0110011, Funct3 = 000, Funct7b5 = 1 -> sequence FETCH, DECODE, EXECR (Operation = ALU_SUB), ALUWB (RegWrite = 1, ResultSrc = 00).
- Branch not taken: beq (Funct3 = 000) with CmpResult = 0 -> Operation = ALU_EQUAL, PCWrite = 0. Same with bgeu (Funct3 = 111) and CmpResult = 1 -> ALU_GTU, PCWrite = 1.
- Load with 2 wait cycles: lw -> MEMADR (SrcA = 10, SrcB = 01), then MEMREAD holding AdrSrc = 1 for 3 cycles, then MEMWB (ResultSrc = 01, RegWrite = 1).
- JALR: JALR1, then JALR2 (PCWrite = 1, JalrMask = 1), then ALUWB. Opcode = 1111111 -> TRAP, IllegalInstr = 1, stays 0 on strobes for 10 cycles.
- Reset asserted during MEMWRITE wait -> MemReq and MemWrite fall immediately; after deassert, state is FETCH and IllegalInstr = 0.
